minesweeper_game_fsm: RTL
=========================

Name: minesweeper_game_fsm

Overview:
- Parametrised next-generation top-level game controller for the Minesweeper board.
- Sequences board clear, mine generation, play, pause, win and loss.
- Adds difficulty modes, a counted board-clear interval, a gen_done handshake, an on-chip elapsed-time counter and per-difficulty best-time tracking with new-record detection.
- Sits between the board/mine generator, the VGA renderer and the 7-seg timer display.

Parameters:
- CLEAR_CYCLES, 64: cycles spent in CLEAR with reset_out low; must be >= 1.
- TIME_W, 10: width of elapsed and best-time counters, in seconds.
- MINE_W, 7: width of mine_count.
- MINES_EASY, 10: mine count for difficulty 0.
- MINES_MED, 25: mine count for difficulty 1.
- MINES_HARD, 40: mine count for difficulty 2 and 3.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_in  in  1  synchronous, active-high reset.
- go  in  1  start/restart request, sampled each cycle.
- difficulty  in  2  mode select, latched when a game is started.
- gen_done  in  1  mine generator finished.
- is_win  in  1  board reports all safe cells revealed.
- is_loss  in  1  board reports a mine revealed.
- tick  in  1  one-cycle 1 Hz enable.
- pause_req  in  1  pause toggle request; used only with the optional feature.
- reset_out  out  1  active-low board/mine-RAM clear.
- enable_mine_generation  out  1  mine generator run.
- mine_count  out  MINE_W  mine count for the latched mode.
- enable_vga  out  1  renderer enable.
- clock_run  out  1  game timer running.
- playing  out  1  board accepts player input.
- compare_high_score  out  1  high in WIN.
- new_record  out  1  one-cycle pulse on WIN entry when the game beat the stored best time.
- elapsed  out  TIME_W  seconds in the current game.
- best_time  out  TIME_W  stored best time for the latched mode; all-ones means no record.
- state  out  3  encoded current state, for debug LEDs.

Behaviour:
- State encoding:
  - IDLE = 0
  - CLEAR = 1
  - GENERATE = 2
  - IN_GAME = 3
  - WIN = 4
  - LOSE = 5
  - PAUSED = 6
  - 7 is unused and recovers to CLEAR.
- Registered state; outputs are decoded combinationally from the current state, except new_record, elapsed, best_time and mine_count, which are registered.
- Default outputs in every state: reset_out = 1, enable_vga = 1, all other 1-bit outputs = 0.
- Transitions:
  - IDLE -> CLEAR on go.
  - CLEAR: reset_out = 0, enable_vga = 0. Counter loads 0 on entry and increments each cycle. Exit to GENERATE after exactly CLEAR_CYCLES cycles in CLEAR.
  - GENERATE: enable_mine_generation = 1. Remain until gen_done, then go to IN_GAME. There is no timeout.
  - IN_GAME: playing = 1, clock_run = 1. Next state is WIN if is_win, else LOSE if is_loss, else IN_GAME. Win has priority when both are asserted. go is ignored.
  - WIN: compare_high_score = 1. go -> CLEAR.
  - LOSE: go -> CLEAR.
- Difficulty latch:
  - difficulty is latched on the cycle go causes IDLE/WIN/LOSE -> CLEAR.
  - mine_count updates on the next cycle from the latched mode; modes 2 and 3 both select MINES_HARD.
- Elapsed counter:
  - Cleared in CLEAR.
  - +1 on tick only while in IN_GAME.
  - Saturates at 2^TIME_W-1; no wrap.
  - Holds its value in WIN, LOSE and PAUSED.
- Best time:
  - Three registers, one each for easy, medium and hard.
  - On the IN_GAME -> WIN transition: if elapsed < best[mode], write elapsed into best[mode] and pulse new_record for exactly one cycle, the first WIN cycle.
  - Equal times are not a record.
  - A tick arriving on the win cycle is not counted.
  - Loss never updates best times.
- Reset:
  - reset_in = 1 forces IDLE, latched mode = 0, elapsed = 0, all best times = all-ones, new_record = 0, clear counter = 0.
  - In IDLE: reset_out = 1, enable_vga = 1, mine_count = MINES_EASY.
  - Reset overrides all inputs and aborts any state in progress.

Optional Feature:
- Macro: MINESWEEPER_PAUSE_EN.
- When defined:
  - A pause_req rising edge (registered edge detect) moves IN_GAME -> PAUSED, and PAUSED -> IN_GAME.
  - PAUSED: enable_vga = 0 (board hidden), playing = 0, clock_run = 0, ticks ignored.
  - In PAUSED, go -> CLEAR (abandon the game).
  - In IN_GAME, is_win/is_loss take priority over a pause edge in the same cycle.
- When undefined:
  - pause_req is unused.
  - PAUSED is unreachable and state 6 recovers to CLEAR like state 7.

Test Plan:
- Reset, then go with difficulty = 1, CLEAR_CYCLES = 4 -> reset_out low for exactly 4 cycles; GENERATE entered; mine_count = 25.
- In GENERATE, hold gen_done = 0 for 20 cycles, then pulse it -> enable_mine_generation high all 20 cycles; next state IN_GAME with playing = 1 and clock_run = 1.
- In IN_GAME give 7 ticks, then is_win = is_loss = 1 in the same cycle -> WIN; elapsed = 7; best_time = 7; new_record pulses for 1 cycle.
- Replay the same mode and win at 7 s, then at 5 s -> first win: no new_record, best stays 7; second win: new_record pulses, best = 5; the other modes' best stays all-ones.
- With TIME_W = 3, give 10 ticks -> elapsed saturates at 7; assert reset_in mid-game -> IDLE next cycle, elapsed = 0, best times all-ones.
- With MINESWEEPER_PAUSE_EN defined: pause edge after 3 ticks, 5 ticks while paused, unpause edge, 2 more ticks -> elapsed = 5; enable_vga = 0 while paused.

Source files
------------

// File: rtl/minesweeper_game_fsm_if.sv
// Controller-side signal bundle for minesweeper_game_fsm: board/generator
// status and timing inputs, plus control, timer and best-time outputs.
interface minesweeper_game_fsm_if #(
  parameter int unsigned TIME_W = 10,
  parameter int unsigned MINE_W = 7
);
  logic              go;
  logic [1:0]        difficulty;
  logic              gen_done;
  logic              is_win;
  logic              is_loss;
  logic              tick;
  logic              pause_req;
  logic              reset_out;
  logic              enable_mine_generation;
  logic [MINE_W-1:0] mine_count;
  logic              enable_vga;
  logic              clock_run;
  logic              playing;
  logic              compare_high_score;
  logic              new_record;
  logic [TIME_W-1:0] elapsed;
  logic [TIME_W-1:0] best_time;
  logic [2:0]        state;

  modport master (
    input  go, difficulty, gen_done, is_win, is_loss, tick, pause_req,
    output reset_out, enable_mine_generation, mine_count, enable_vga,
           clock_run, playing, compare_high_score, new_record, elapsed,
           best_time, state
  );

  modport slave (
    output go, difficulty, gen_done, is_win, is_loss, tick, pause_req,
    input  reset_out, enable_mine_generation, mine_count, enable_vga,
           clock_run, playing, compare_high_score, new_record, elapsed,
           best_time, state
  );
endinterface

// File: rtl/minesweeper_game_fsm.sv
// Minesweeper top-level game controller: clear/generate/play/win/lose sequencing,
// elapsed timer and per-difficulty best times. Optional pause: MINESWEEPER_PAUSE_EN.
module minesweeper_game_fsm #(
  parameter int unsigned CLEAR_CYCLES = 64,
  parameter int unsigned TIME_W       = 10,
  parameter int unsigned MINE_W       = 7,
  parameter int unsigned MINES_EASY   = 10,
  parameter int unsigned MINES_MED    = 25,
  parameter int unsigned MINES_HARD   = 40
) (
  input  logic                  clk,
  input  logic                  reset_in,
  minesweeper_game_fsm_if.master bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    GENERATE = 3'd2,
    IN_GAME  = 3'd3,
    WIN      = 3'd4,
    LOSE     = 3'd5,
    PAUSED   = 3'd6,
    UNUSED   = 3'd7
  } state_e;

  localparam int unsigned       CNT_W    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [TIME_W-1:0] TIME_MAX = '1;

  // Modes 2 and 3 share the hard mine count and the hard best-time slot.
  function automatic logic [1:0] best_idx(input logic [1:0] m);
    return (m == 2'd3) ? 2'd2 : m;
  endfunction

  function automatic logic [MINE_W-1:0] mines_for(input logic [1:0] m);
    case (m)
      2'd0:    return MINE_W'(MINES_EASY);
      2'd1:    return MINE_W'(MINES_MED);
      default: return MINE_W'(MINES_HARD);
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [TIME_W-1:0] elapsed_q, elapsed_d;
  logic [TIME_W-1:0] best_q [3];
  logic [TIME_W-1:0] best_d [3];
  logic [TIME_W-1:0] best_time_q, best_time_d;
  logic [MINE_W-1:0] mine_count_q, mine_count_d;
  logic              new_record_q, new_record_d;
  logic              start;

`ifdef MINESWEEPER_PAUSE_EN
  logic pause_req_q, pause_req_d;
  logic pause_edge;
  assign pause_req_d = bus.pause_req;
  assign pause_edge  = bus.pause_req & ~pause_req_q;
`else
  logic unused_pause_req;
  assign unused_pause_req = bus.pause_req;
`endif

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    mode_d       = mode_q;
    elapsed_d    = elapsed_q;
    best_d       = best_q;
    new_record_d = 1'b0;
    start        = 1'b0;
    case (state_q)
      IDLE:     start = bus.go;
      CLEAR: begin
        elapsed_d = '0;
        if (clr_cnt_q == CNT_LAST) state_d = GENERATE;
        else                       clr_cnt_d = clr_cnt_q + 1'b1;
      end
      GENERATE: if (bus.gen_done) state_d = IN_GAME;
      IN_GAME: begin
        // The win cycle freezes elapsed so the recorded time excludes its tick.
        if (bus.is_win) begin
          state_d = WIN;
          if (elapsed_q < best_q[best_idx(mode_q)]) begin
            best_d[best_idx(mode_q)] = elapsed_q;
            new_record_d             = 1'b1;
          end
        end else begin
          if (bus.tick && (elapsed_q != TIME_MAX)) elapsed_d = elapsed_q + 1'b1;
          if (bus.is_loss) state_d = LOSE;
`ifdef MINESWEEPER_PAUSE_EN
          else if (pause_edge) state_d = PAUSED;
`endif
        end
      end
      WIN, LOSE: start = bus.go;
`ifdef MINESWEEPER_PAUSE_EN
      PAUSED: begin
        if (bus.go)          start   = 1'b1;
        else if (pause_edge) state_d = IN_GAME;
      end
`endif
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
    if (start) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
      mode_d    = bus.difficulty;
    end
    best_time_d  = best_d[best_idx(mode_d)];
    mine_count_d = mines_for(mode_q);
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      mode_q       <= '0;
      elapsed_q    <= '0;
      for (int unsigned i = 0; i < 3; i++) best_q[i] <= '1;
      best_time_q  <= '1;
      mine_count_q <= MINE_W'(MINES_EASY);
      new_record_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      mode_q       <= mode_d;
      elapsed_q    <= elapsed_d;
      best_q       <= best_d;
      best_time_q  <= best_time_d;
      mine_count_q <= mine_count_d;
      new_record_q <= new_record_d;
    end
  end

`ifdef MINESWEEPER_PAUSE_EN
  always_ff @(posedge clk) begin
    if (reset_in) pause_req_q <= 1'b0;
    else          pause_req_q <= pause_req_d;
  end
`endif

  always_comb begin
    bus.reset_out              = 1'b1;
    bus.enable_vga             = 1'b1;
    bus.enable_mine_generation = 1'b0;
    bus.playing                = 1'b0;
    bus.clock_run              = 1'b0;
    bus.compare_high_score     = 1'b0;
    case (state_q)
      CLEAR: begin
        bus.reset_out  = 1'b0;
        bus.enable_vga = 1'b0;
      end
      GENERATE: bus.enable_mine_generation = 1'b1;
      IN_GAME: begin
        bus.playing   = 1'b1;
        bus.clock_run = 1'b1;
      end
      WIN:      bus.compare_high_score = 1'b1;
`ifdef MINESWEEPER_PAUSE_EN
      PAUSED:   bus.enable_vga = 1'b0;
`endif
      default: ;
    endcase
  end

  assign bus.state      = state_q;
  assign bus.mine_count = mine_count_q;
  assign bus.new_record = new_record_q;
  assign bus.elapsed    = elapsed_q;
  assign bus.best_time  = best_time_q;

endmodule
